// File: rtl/sdrc_req_splitter.sv
// sdrc_req_splitter
//   Accepts one application request at a time and breaks it into bank-side
//   chunks. A chunk never crosses an SDRAM page (column) boundary, unless the
//   request is in wrap mode. Application addresses and lengths are counted in
//   application words. They are rescaled to SDR words according to the SDRAM
//   data width, then decoded into column, bank and row fields.
//
//   Optional feature: define SDRC_REQ_CHUNK_CAP_EN to also limit each chunk to
//   cfg_max_chunk SDR words. A value of 0 means no cap. When the macro is not
//   defined, cfg_max_chunk is ignored and no cap logic is built.
//
// Ports
//   clk, reset_n        : clock (rising edge) and asynchronous active-low reset
//   cfg_colbits         : column width, 8 + cfg_colbits bits
//   sdr_width           : SDRAM width (00=32b, 01=16b, 1x=8b); sets address/length scaling
//   cfg_max_chunk       : chunk length cap in SDR words (only with the macro above)
//   req, req_id, req_addr, req_len, req_wr_n, req_wrap : application request
//   req_ack             : combinational accept pulse, only in IDLE
//   r2x_idle            : splitter idle and no request pending
//   r2b_*               : registered chunk request towards the bank controller
//   b2r_ack, b2r_arb_ok : bank controller handshake
//   zero_len_drop       : one-cycle pulse when a zero-length request is dropped
module sdrc_req_splitter #(
  parameter int APP_AW = 26,
  parameter int APP_RW = 9,
  parameter int REQ_BW = 12,
  parameter int BA_W   = 2,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        cfg_colbits,
  input  logic [1:0]        sdr_width,
  input  logic [REQ_BW-1:0] cfg_max_chunk,
  input  logic              req,
  input  logic [ID_W-1:0]   req_id,
  input  logic [APP_AW-1:0] req_addr,
  input  logic [APP_RW-1:0] req_len,
  input  logic              req_wr_n,
  input  logic              req_wrap,
  output logic              req_ack,
  output logic              r2x_idle,
  output logic              r2b_req,
  output logic [ID_W-1:0]   r2b_req_id,
  output logic              r2b_start,
  output logic              r2b_last,
  output logic              r2b_wrap,
  output logic              r2b_write,
  output logic [BA_W-1:0]   r2b_ba,
  output logic [12:0]       r2b_raddr,
  output logic [12:0]       r2b_caddr,
  output logic [REQ_BW-1:0] r2b_len,
  input  logic              b2r_ack,
  input  logic              b2r_arb_ok,
  output logic              zero_len_drop
);

  // The scaled address gains two bits, so that 8-bit SDRAM addressing wraps modulo 2^(APP_AW+2).
  localparam int SAW = APP_AW + 2;
  // Page remaining can reach 2048 (11 column bits), so the comparison needs at least 12 bits.
  localparam int MW  = (REQ_BW > 12) ? REQ_BW : 12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SAW-1:0]    addr_q, addr_d;
  logic [REQ_BW-1:0] rem_q, rem_d;
  logic [1:0]        colbits_q, colbits_d;

  logic              r2b_req_q, r2b_req_d;
  logic [ID_W-1:0]   r2b_req_id_q, r2b_req_id_d;
  logic              r2b_start_q, r2b_start_d;
  logic              r2b_last_q, r2b_last_d;
  logic              r2b_wrap_q, r2b_wrap_d;
  logic              r2b_write_q, r2b_write_d;
  logic [BA_W-1:0]   r2b_ba_q, r2b_ba_d;
  logic [12:0]       r2b_raddr_q, r2b_raddr_d;
  logic [12:0]       r2b_caddr_q, r2b_caddr_d;
  logic [REQ_BW-1:0] r2b_len_q, r2b_len_d;

`ifdef SDRC_REQ_CHUNK_CAP_EN
  logic [REQ_BW-1:0] cap_q, cap_d;
  logic [REQ_BW-1:0] src_cap;
`else
  logic unused_cap;
  assign unused_cap = ^cfg_max_chunk;
`endif

  logic              ack;
  logic [1:0]        sh;
  logic [SAW-1:0]    s_addr;
  logic [REQ_BW-1:0] s_len;

  logic [SAW-1:0]    src_addr;
  logic [REQ_BW-1:0] src_rem;
  logic [1:0]        src_colbits;
  logic              src_wrap;

  logic [3:0]        cbits;
  logic [MW-1:0]     page_rem;
  logic [MW-1:0]     clen;
  logic [12:0]       ch_caddr;
  logic [BA_W-1:0]   ch_ba;
  logic [12:0]       ch_raddr;
  logic [REQ_BW-1:0] ch_len;
  logic              ch_last;

  // Accept only in IDLE. Reset is included so that req_ack stays low during reset.
  assign ack           = reset_n & (state_q == ST_IDLE) & req & b2r_arb_ok;
  assign req_ack       = ack;
  assign r2x_idle      = (state_q == ST_IDLE) & ~req;
  assign zero_len_drop = (state_q == ST_DROP);

  // Convert the incoming request from application words to SDR words.
  always_comb begin
    case (sdr_width)
      2'b00:   sh = 2'd0;
      2'b01:   sh = 2'd1;
      default: sh = 2'd2;
    endcase
    s_addr = SAW'(req_addr) << sh;
    s_len  = REQ_BW'(req_len) << sh;
  end

  // Select where the next chunk comes from. In IDLE it comes from the incoming
  // request. In ISSUE it comes from the held state, advanced past the chunk
  // that is currently being acknowledged.
  always_comb begin
    if (state_q == ST_ISSUE) begin
      src_addr    = addr_q + SAW'(r2b_len_q);
      src_rem     = rem_q - r2b_len_q;
      src_colbits = colbits_q;
      src_wrap    = r2b_wrap_q;
`ifdef SDRC_REQ_CHUNK_CAP_EN
      src_cap     = cap_q;
`endif
    end else begin
      src_addr    = s_addr;
      src_rem     = s_len;
      src_colbits = cfg_colbits;
      src_wrap    = req_wrap;
`ifdef SDRC_REQ_CHUNK_CAP_EN
      src_cap     = cfg_max_chunk;
`endif
    end
  end

  // Decode the address into column, bank and row, then size the chunk.
  // Wrap mode sends the whole request as one chunk and lets the bank side
  // wrap inside the page.
  always_comb begin
    cbits    = 4'd8 + {2'b00, src_colbits};
    ch_caddr = 13'(src_addr) & ((13'd1 << cbits) - 13'd1);
    ch_ba    = BA_W'(src_addr >> cbits);
    ch_raddr = 13'(src_addr >> (cbits + 4'(BA_W)));
    page_rem = (MW'(1) << cbits) - MW'(ch_caddr);
    clen     = MW'(src_rem);
    if (!src_wrap) begin
      if (page_rem < clen) clen = page_rem;
`ifdef SDRC_REQ_CHUNK_CAP_EN
      if ((src_cap != '0) && (MW'(src_cap) < clen)) clen = MW'(src_cap);
`endif
    end
    ch_len  = REQ_BW'(clen);
    ch_last = (ch_len == src_rem);
  end

  // Request sequencing. When a chunk is loaded, the r2b fields for that chunk
  // are captured together. The bank side then sees them one cycle after
  // req_ack, or one cycle after b2r_ack.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    colbits_d    = colbits_q;
    r2b_req_d    = r2b_req_q;
    r2b_req_id_d = r2b_req_id_q;
    r2b_start_d  = r2b_start_q;
    r2b_last_d   = r2b_last_q;
    r2b_wrap_d   = r2b_wrap_q;
    r2b_write_d  = r2b_write_q;
    r2b_ba_d     = r2b_ba_q;
    r2b_raddr_d  = r2b_raddr_q;
    r2b_caddr_d  = r2b_caddr_q;
    r2b_len_d    = r2b_len_q;
`ifdef SDRC_REQ_CHUNK_CAP_EN
    cap_d        = cap_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ack) begin
          colbits_d    = cfg_colbits;
          r2b_wrap_d   = req_wrap;
          r2b_write_d  = ~req_wr_n;
          r2b_req_id_d = req_id;
`ifdef SDRC_REQ_CHUNK_CAP_EN
          cap_d        = cfg_max_chunk;
`endif
          if (s_len == '0) begin
            state_d = ST_DROP;
          end else begin
            state_d     = ST_ISSUE;
            r2b_req_d   = 1'b1;
            r2b_start_d = 1'b1;
            addr_d      = src_addr;
            rem_d       = src_rem;
            r2b_caddr_d = ch_caddr;
            r2b_ba_d    = ch_ba;
            r2b_raddr_d = ch_raddr;
            r2b_len_d   = ch_len;
            r2b_last_d  = ch_last;
          end
        end
      end
      ST_DROP: begin
        state_d = ST_IDLE;
      end
      ST_ISSUE: begin
        if (b2r_ack) begin
          if (src_rem == '0) begin
            state_d     = ST_IDLE;
            r2b_req_d   = 1'b0;
            r2b_start_d = 1'b0;
            r2b_last_d  = 1'b0;
          end else begin
            r2b_start_d = 1'b0;
            addr_d      = src_addr;
            rem_d       = src_rem;
            r2b_caddr_d = ch_caddr;
            r2b_ba_d    = ch_ba;
            r2b_raddr_d = ch_raddr;
            r2b_len_d   = ch_len;
            r2b_last_d  = ch_last;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        r2b_req_d = 1'b0;
      end
    endcase
  end

  // All state and every registered output clears on reset. Any chunks still pending are discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      colbits_q    <= '0;
      r2b_req_q    <= 1'b0;
      r2b_req_id_q <= '0;
      r2b_start_q  <= 1'b0;
      r2b_last_q   <= 1'b0;
      r2b_wrap_q   <= 1'b0;
      r2b_write_q  <= 1'b0;
      r2b_ba_q     <= '0;
      r2b_raddr_q  <= '0;
      r2b_caddr_q  <= '0;
      r2b_len_q    <= '0;
`ifdef SDRC_REQ_CHUNK_CAP_EN
      cap_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      colbits_q    <= colbits_d;
      r2b_req_q    <= r2b_req_d;
      r2b_req_id_q <= r2b_req_id_d;
      r2b_start_q  <= r2b_start_d;
      r2b_last_q   <= r2b_last_d;
      r2b_wrap_q   <= r2b_wrap_d;
      r2b_write_q  <= r2b_write_d;
      r2b_ba_q     <= r2b_ba_d;
      r2b_raddr_q  <= r2b_raddr_d;
      r2b_caddr_q  <= r2b_caddr_d;
      r2b_len_q    <= r2b_len_d;
`ifdef SDRC_REQ_CHUNK_CAP_EN
      cap_q        <= cap_d;
`endif
    end
  end

  assign r2b_req    = r2b_req_q;
  assign r2b_req_id = r2b_req_id_q;
  assign r2b_start  = r2b_start_q;
  assign r2b_last   = r2b_last_q;
  assign r2b_wrap   = r2b_wrap_q;
  assign r2b_write  = r2b_write_q;
  assign r2b_ba     = r2b_ba_q;
  assign r2b_raddr  = r2b_raddr_q;
  assign r2b_caddr  = r2b_caddr_q;
  assign r2b_len    = r2b_len_q;

endmodule

// File: tb/tb_sdrc_req_splitter.sv
// tb_sdrc_req_splitter
//   Directed bench for sdrc_req_splitter with default parameters. A table of
//   requests lists the hand-computed chunks that each request must produce.
//   Hand-written sequences cover reset, dropping a zero-length request,
//   holding the chunk fields while b2r_ack is low, and reset in the middle of
//   a request. Inputs are driven and outputs are sampled on the falling edge.
module tb_sdrc_req_splitter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  cfg_colbits;
  logic [1:0]  sdr_width;
  logic [11:0] cfg_max_chunk;
  logic        req;
  logic [3:0]  req_id;
  logic [25:0] req_addr;
  logic [8:0]  req_len;
  logic        req_wr_n;
  logic        req_wrap;
  logic        req_ack;
  logic        r2x_idle;
  logic        r2b_req;
  logic [3:0]  r2b_req_id;
  logic        r2b_start;
  logic        r2b_last;
  logic        r2b_wrap;
  logic        r2b_write;
  logic [1:0]  r2b_ba;
  logic [12:0] r2b_raddr;
  logic [12:0] r2b_caddr;
  logic [11:0] r2b_len;
  logic        b2r_ack;
  logic        b2r_arb_ok;
  logic        zero_len_drop;

  int numChecks = 0;
  int numFails  = 0;

  typedef struct {
    logic [1:0]        colbits;
    logic [1:0]        width;
    logic              wrap;
    logic [11:0]       cap;
    logic [25:0]       addr;
    logic [8:0]        len;
    logic [3:0]        id;
    logic              wrN;
    int                nck;
    logic [7:0][12:0]  caddr;
    logic [7:0][1:0]   ba;
    logic [7:0][12:0]  row;
    logic [7:0][11:0]  clen;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  sdrc_req_splitter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_colbits   (cfg_colbits),
    .sdr_width     (sdr_width),
    .cfg_max_chunk (cfg_max_chunk),
    .req           (req),
    .req_id        (req_id),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .req_wr_n      (req_wr_n),
    .req_wrap      (req_wrap),
    .req_ack       (req_ack),
    .r2x_idle      (r2x_idle),
    .r2b_req       (r2b_req),
    .r2b_req_id    (r2b_req_id),
    .r2b_start     (r2b_start),
    .r2b_last      (r2b_last),
    .r2b_wrap      (r2b_wrap),
    .r2b_write     (r2b_write),
    .r2b_ba        (r2b_ba),
    .r2b_raddr     (r2b_raddr),
    .r2b_caddr     (r2b_caddr),
    .r2b_len       (r2b_len),
    .b2r_ack       (b2r_ack),
    .b2r_arb_ok    (b2r_arb_ok),
    .zero_len_drop (zero_len_drop)
  );

  // Free-running clock with a 10-unit period
  always #5 clk = ~clk;

  // A single comparison with a failure report
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setReq(input int v, input logic [1:0] colbits, input logic [1:0] width,
                        input logic wrap, input logic [11:0] cap, input logic [25:0] addr,
                        input logic [8:0] len, input logic [3:0] id, input logic wrN, input int nck);
    vecs[v].colbits = colbits;
    vecs[v].width   = width;
    vecs[v].wrap    = wrap;
    vecs[v].cap     = cap;
    vecs[v].addr    = addr;
    vecs[v].len     = len;
    vecs[v].id      = id;
    vecs[v].wrN     = wrN;
    vecs[v].nck     = nck;
    vecs[v].caddr   = '0;
    vecs[v].ba      = '0;
    vecs[v].row     = '0;
    vecs[v].clen    = '0;
  endtask

  task automatic setChunk(input int v, input int k, input logic [12:0] caddr,
                          input logic [1:0] ba, input logic [12:0] row, input logic [11:0] clen);
    vecs[v].caddr[k] = caddr;
    vecs[v].ba[k]    = ba;
    vecs[v].row[k]   = row;
    vecs[v].clen[k]  = clen;
  endtask

  // Expected chunk lists, worked out by hand from address decoding and page sizes
  task automatic fillTable();
    // 0x0F0 is 0x10 words before the end of a 256-word page. The second chunk carries into bank 1.
    setReq(0, 2'b00, 2'b00, 1'b0, 12'h000, 26'h00000F0, 9'h020, 4'h1, 1'b1, 2);
    setChunk(0, 0, 13'h0F0, 2'd0, 13'h0000, 12'h010);
    setChunk(0, 1, 13'h000, 2'd1, 13'h0000, 12'h010);
    // The same request in wrap mode goes out as one full-length chunk
    setReq(1, 2'b00, 2'b00, 1'b1, 12'h000, 26'h00000F0, 9'h020, 4'h2, 1'b1, 1);
    setChunk(1, 0, 13'h0F0, 2'd0, 13'h0000, 12'h020);
    // 16-bit SDRAM: address 0x7C becomes 0xF8 and length 0x10 becomes 0x20. This one is a write.
    setReq(2, 2'b00, 2'b01, 1'b0, 12'h000, 26'h000007C, 9'h010, 4'h5, 1'b0, 2);
    setChunk(2, 0, 13'h0F8, 2'd0, 13'h0000, 12'h008);
    setChunk(2, 1, 13'h000, 2'd1, 13'h0000, 12'h018);
    // 9-bit columns with cap 0x40: split only when the cap is built in
`ifdef SDRC_REQ_CHUNK_CAP_EN
    setReq(3, 2'b01, 2'b00, 1'b0, 12'h040, 26'h0000000, 9'h1F0, 4'h3, 1'b1, 8);
    for (int k = 0; k < 7; k++) setChunk(3, k, 13'(k * 64), 2'd0, 13'h0000, 12'h040);
    setChunk(3, 7, 13'h1C0, 2'd0, 13'h0000, 12'h030);
`else
    setReq(3, 2'b01, 2'b00, 1'b0, 12'h040, 26'h0000000, 9'h1F0, 4'h3, 1'b1, 1);
    setChunk(3, 0, 13'h000, 2'd0, 13'h0000, 12'h1F0);
`endif
    // 8-bit SDRAM with 11-bit columns: scaled address 0xBFFC is row 5, bank 3, column 0x7FC.
    // The next chunk carries through the bank field into row 6.
    setReq(4, 2'b11, 2'b10, 1'b0, 12'h000, 26'h0002FFF, 9'h003, 4'h4, 1'b1, 2);
    setChunk(4, 0, 13'h7FC, 2'd3, 13'h0005, 12'h004);
    setChunk(4, 1, 13'h000, 2'd0, 13'h0006, 12'h008);
    // Top of the address space: scaled 0xFFFFFFC wraps modulo 2^28 back to zero
    setReq(5, 2'b00, 2'b10, 1'b0, 12'h000, 26'h3FFFFFF, 9'h002, 4'hA, 1'b1, 2);
    setChunk(5, 0, 13'h0FC, 2'd3, 13'h1FFF, 12'h004);
    setChunk(5, 1, 13'h000, 2'd0, 13'h0000, 12'h004);
  endtask

  task automatic driveReq(input logic [1:0] colbits, input logic [1:0] width, input logic wrap,
                          input logic [11:0] cap, input logic [25:0] addr, input logic [8:0] len,
                          input logic [3:0] id, input logic wrN);
    cfg_colbits   = colbits;
    sdr_width     = width;
    req_wrap      = wrap;
    cfg_max_chunk = cap;
    req_addr      = addr;
    req_len       = len;
    req_id        = id;
    req_wr_n      = wrN;
    req           = 1'b1;
  endtask

  // Run one table request. b2r_ack is given immediately for every chunk.
  task automatic applyStimulus(input int v);
    string tag;
    @(negedge clk);
    driveReq(vecs[v].colbits, vecs[v].width, vecs[v].wrap, vecs[v].cap,
             vecs[v].addr, vecs[v].len, vecs[v].id, vecs[v].wrN);
    #1;
    checkOutput($sformatf("v%0d_req_ack", v), {31'd0, req_ack}, 32'd1);
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < vecs[v].nck; k++) begin
      tag = $sformatf("v%0d_c%0d", v, k);
      checkOutput({tag, "_req"},   {31'd0, r2b_req},   32'd1);
      checkOutput({tag, "_start"}, {31'd0, r2b_start}, (k == 0) ? 32'd1 : 32'd0);
      checkOutput({tag, "_last"},  {31'd0, r2b_last},  (k == vecs[v].nck - 1) ? 32'd1 : 32'd0);
      checkOutput({tag, "_caddr"}, {19'd0, r2b_caddr}, {19'd0, vecs[v].caddr[k]});
      checkOutput({tag, "_ba"},    {30'd0, r2b_ba},    {30'd0, vecs[v].ba[k]});
      checkOutput({tag, "_raddr"}, {19'd0, r2b_raddr}, {19'd0, vecs[v].row[k]});
      checkOutput({tag, "_len"},   {20'd0, r2b_len},   {20'd0, vecs[v].clen[k]});
      checkOutput({tag, "_id"},    {28'd0, r2b_req_id}, {28'd0, vecs[v].id});
      checkOutput({tag, "_write"}, {31'd0, r2b_write}, {31'd0, ~vecs[v].wrN});
      checkOutput({tag, "_wrap"},  {31'd0, r2b_wrap},  {31'd0, vecs[v].wrap});
      b2r_ack = 1'b1;
      @(posedge clk);
      #1 b2r_ack = 1'b0;
      @(negedge clk);
    end
    checkOutput($sformatf("v%0d_done_req", v),  {31'd0, r2b_req},  32'd0);
    checkOutput($sformatf("v%0d_done_idle", v), {31'd0, r2x_idle}, 32'd1);
  endtask

  // Main sequence
  initial begin
    reset_n    = 1'b0;
    req        = 1'b0;
    b2r_ack    = 1'b0;
    b2r_arb_ok = 1'b1;
    driveReq(2'b00, 2'b00, 1'b0, 12'h000, 26'h0, 9'h0, 4'h0, 1'b1);
    req = 1'b0;
    fillTable();

    // Reset state: outputs cleared, no accept, idle follows ~req
    @(negedge clk);
    req = 1'b1;
    #1;
    checkOutput("rst_req_ack",   {31'd0, req_ack},  32'd0);
    checkOutput("rst_idle_req1", {31'd0, r2x_idle}, 32'd0);
    req = 1'b0;
    #1;
    checkOutput("rst_idle_req0", {31'd0, r2x_idle}, 32'd1);
    checkOutput("rst_r2b_req",   {31'd0, r2b_req},  32'd0);
    checkOutput("rst_r2b_len",   {20'd0, r2b_len},  32'd0);
    checkOutput("rst_zero_drop", {31'd0, zero_len_drop}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven requests
    for (int v = 0; v < NV; v++) applyStimulus(v);

    // The arbiter is not ready, so the request is not accepted
    @(negedge clk);
    driveReq(2'b00, 2'b00, 1'b0, 12'h000, 26'h0F0, 9'h020, 4'h1, 1'b1);
    b2r_arb_ok = 1'b0;
    #1;
    checkOutput("arb_blocked_ack", {31'd0, req_ack}, 32'd0);
    req = 1'b0;
    b2r_arb_ok = 1'b1;

    // A zero-length request is accepted, pulses zero_len_drop and issues no chunk
    @(negedge clk);
    driveReq(2'b00, 2'b00, 1'b0, 12'h000, 26'h123, 9'h000, 4'h7, 1'b1);
    #1;
    checkOutput("zl_ack", {31'd0, req_ack}, 32'd1);
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    checkOutput("zl_drop_pulse", {31'd0, zero_len_drop}, 32'd1);
    checkOutput("zl_no_req",     {31'd0, r2b_req},       32'd0);
    checkOutput("zl_not_idle",   {31'd0, r2x_idle},      32'd0);
    @(negedge clk);
    checkOutput("zl_drop_end",   {31'd0, zero_len_drop}, 32'd0);
    checkOutput("zl_no_req2",    {31'd0, r2b_req},       32'd0);
    checkOutput("zl_idle",       {31'd0, r2x_idle},      32'd1);

    // Hold b2r_ack low for 5 cycles: the fields must stay stable and a new request must not be accepted
    @(negedge clk);
    driveReq(2'b00, 2'b00, 1'b0, 12'h000, 26'h0F0, 9'h020, 4'h6, 1'b1);
    @(posedge clk);
    #1 req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold%0d_req", i),   {31'd0, r2b_req},   32'd1);
      checkOutput($sformatf("hold%0d_caddr", i), {19'd0, r2b_caddr}, 32'h0F0);
      checkOutput($sformatf("hold%0d_len", i),   {20'd0, r2b_len},   32'h010);
      checkOutput($sformatf("hold%0d_start", i), {31'd0, r2b_start}, 32'd1);
    end
    req = 1'b1;
    #1;
    checkOutput("issue_no_ack",  {31'd0, req_ack},  32'd0);
    checkOutput("issue_no_idle", {31'd0, r2x_idle}, 32'd0);
    req = 1'b0;
    b2r_ack = 1'b1;
    @(posedge clk);
    #1 b2r_ack = 1'b0;
    @(negedge clk);
    checkOutput("hold_c1_ba",   {30'd0, r2b_ba},    32'd1);
    checkOutput("hold_c1_last", {31'd0, r2b_last},  32'd1);
    b2r_ack = 1'b1;
    @(posedge clk);
    #1 b2r_ack = 1'b0;
    @(negedge clk);
    // A new request can be accepted in the cycle right after the last b2r_ack
    req = 1'b1;
    #1;
    checkOutput("reaccept_ack", {31'd0, req_ack}, 32'd1);
    req = 1'b0;

    // Three-chunk request (0x10, 0x100, 0x10). Reset is applied for one cycle during chunk 2.
    @(negedge clk);
    driveReq(2'b00, 2'b00, 1'b0, 12'h000, 26'h0F0, 9'h120, 4'h9, 1'b1);
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    checkOutput("mid_c0_len", {20'd0, r2b_len}, 32'h010);
    b2r_ack = 1'b1;
    @(posedge clk);
    #1 b2r_ack = 1'b0;
    @(negedge clk);
    checkOutput("mid_c1_len", {20'd0, r2b_len}, 32'h100);
    checkOutput("mid_c1_ba",  {30'd0, r2b_ba},  32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_req",   {31'd0, r2b_req},   32'd0);
    checkOutput("mid_rst_len",   {20'd0, r2b_len},   32'd0);
    checkOutput("mid_rst_ba",    {30'd0, r2b_ba},    32'd0);
    checkOutput("mid_rst_caddr", {19'd0, r2b_caddr}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_req",  {31'd0, r2b_req},  32'd0);
    checkOutput("post_rst_idle", {31'd0, r2x_idle}, 32'd1);
    applyStimulus(0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/sdrc_req_splitter.md
SDRC_REQ_SPLITTER -- requirements
Module: sdrc_req_splitter

Interface
REQ-001 SHALL have parameter APP_AW, default 26, meaning application address width in application words.
REQ-002 SHALL have parameter APP_RW, default 9, meaning application request length width.
REQ-003 SHALL have parameter REQ_BW, default 12, meaning bank-side chunk length width; must satisfy REQ_BW >= APP_RW+2.
REQ-004 SHALL have parameter BA_W, default 2, meaning bank address width; legal values are 2 or 3.
REQ-005 SHALL have parameter ID_W, default 4, meaning request ID width.
REQ-006 SHALL have ports, in this order:
- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_colbits  in  2  column width: 00=8, 01=9, 10=10, 11=11 bits.
- sdr_width  in  2  SDRAM data width: 00=32-bit, 01=16-bit, 1x=8-bit.
- cfg_max_chunk  in  REQ_BW  chunk length cap in SDR words; 0 means no cap.
- req  in  1  application request valid.
- req_id  in  ID_W  request ID.
- req_addr  in  APP_AW  request address.
- req_len  in  APP_RW  request length.
- req_wr_n  in  1  0=write, 1=read.
- req_wrap  in  1  wrap at page boundary.
- req_ack  out  1  request accepted (one-cycle pulse).
- r2x_idle  out  1  splitter idle with no pending request.
- r2b_req  out  1  chunk valid.
- r2b_req_id  out  ID_W  chunk ID.
- r2b_start  out  1  first chunk of the request.
- r2b_last  out  1  final chunk of the request.
- r2b_wrap  out  1  wrap mode.
- r2b_write  out  1  1=write.
- r2b_ba  out  BA_W  bank address.
- r2b_raddr  out  13  row address.
- r2b_caddr  out  13  column address.
- r2b_len  out  REQ_BW  chunk length.
- b2r_ack  in  1  bank controller accepted the chunk.
- b2r_arb_ok  in  1  bank controller can accept a new request.
- zero_len_drop  out  1  one-cycle pulse: a zero-length request was dropped.

Function
REQ-007 SHALL scale the internal address and length as follows: sdr_width=00 unchanged; 01 shifted left by 1; 1x shifted left by 2.
REQ-008 SHALL map the scaled address as: column = low C bits, where C = 8 + cfg_colbits; bank = the next BA_W bits; row = the next 13 bits. Unused upper caddr bits SHALL be 0.
REQ-009 SHALL implement an FSM with states IDLE, ISSUE, and DROP.
REQ-010 In IDLE, SHALL drive req_ack = req & b2r_arb_ok combinationally and r2x_idle = ~req.
- On ack with a nonzero scaled length, SHALL go to ISSUE.
- On ack with zero length, SHALL go to DROP.
REQ-011 DROP SHALL last one cycle, pulse zero_len_drop, issue no r2b_req, and return to IDLE.
REQ-012 In ISSUE, SHALL hold r2b_req=1 with all r2b_* fields stable until the cycle in which b2r_ack=1.
REQ-013 With wrap=0, chunk length SHALL be min(remaining, page_remaining, cap). page_remaining = 2^C - column. cap applies only when cfg_max_chunk != 0.
REQ-014 With wrap=1, SHALL issue exactly one chunk of the full length and ignore both the page limit and the cap.
REQ-015 On b2r_ack, SHALL advance the address by r2b_len and reduce remaining by r2b_len.
- If remaining becomes 0, SHALL return to IDLE.
- Otherwise SHALL stay in ISSUE with new fields valid in the next cycle; a request may split into any number of chunks.
REQ-016 Address increment SHALL carry naturally from column into bank and then row, and SHALL wrap modulo 2^(APP_AW+2).
REQ-017 r2b_start SHALL be 1 only on the first chunk; r2b_last SHALL be 1 only when chunk length equals remaining.
REQ-018 All r2b_* outputs SHALL be registered. First r2b_req SHALL assert the cycle after req_ack, giving one cycle of latency.
REQ-019 req_ack SHALL never assert outside IDLE, so a new request can be accepted no earlier than the cycle after the last b2r_ack.
REQ-020 Configuration inputs SHALL be sampled only at req_ack and SHALL be held for the whole request.

Reset
REQ-021 While reset_n=0, SHALL put the FSM in IDLE and drive every registered output to 0. req_ack SHALL be 0; r2x_idle SHALL follow ~req.
REQ-022 Reset during ISSUE SHALL discard the pending chunks, and no r2b_req SHALL assert in the first cycle after release.

Configuration
REQ-023 Macro SDRC_REQ_CHUNK_CAP_EN:
- When defined, cfg_max_chunk SHALL limit chunk length per REQ-013.
- When undefined, cfg_max_chunk SHALL be ignored, no cap logic SHALL be built, and splitting SHALL occur at page boundaries only.

Verification
REQ-024 colbits=00, width=00, addr=0x0F0, len=0x20, wrap=0, cap=0 -> chunks (caddr 0xF0, len 0x10, start) then (bank+1, caddr 0x00, len 0x10, last).
REQ-025 Same request with wrap=1 -> single chunk, caddr 0xF0, len 0x20, start=last=1.
REQ-026 With the macro defined: colbits=01, addr=0, len=0x1F0, cap=0x40 -> 7 chunks of 0x40 then one of 0x30; only the final chunk has last.
REQ-027 width=01, colbits=00, addr=0x7C, len=0x10 -> scaled addr 0xF8, scaled len 0x20 -> chunks of len 8 and 0x18.
REQ-028 len=0 -> req_ack, zero_len_drop pulse one cycle later, no r2b_req; b2r_ack held low for 5 cycles mid-ISSUE -> fields stable throughout.
REQ-029 reset_n low for 1 cycle during chunk 2 of 3 -> all outputs 0; next request accepted normally with start=1.
